// File: rtl/pc_sequencer.sv
// Four-phase instruction sequencer: the program counter, the branch decision from the
// stored ALU flags, and a 4-entry return-address stack for call and return.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction register load (irWrite)
// EXEC   | datapath execute (exeEn); next PC, taken, flags and RAS are registered here
// UPDATE | PC takes the registered next PC
module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic [3:0] fcode,
  input  logic [9:0] label,
  input  logic       flagWe,
  input  logic       carryIn,
  input  logic       zIn,
  input  logic       overflowIn,
  input  logic       signIn,
  output logic [9:0] PC,
  output logic       irWrite,
  output logic       exeEn,
  output logic       taken,
  output logic [1:0] state,
  output logic       rasErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    EXEC   = 2'b10,
    UPDATE = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q;           // {C,Z,V,S}
  logic [9:0]  next_pc_q;
  logic [9:0]  ras [4];
  logic [2:0]  ras_cnt;
  logic [1:0]  top_idx;
  logic [9:0]  pc_inc;
  logic [9:0]  br_target;
  logic [9:0]  next_pc;
  logic        br_take;
  logic        push;
  logic        pop;
  logic        err_set;

  assign state   = state_q;
  assign irWrite = (state_q == FETCH);
  assign exeEn   = (state_q == EXEC);
  assign pc_inc  = PC + 10'd1;
  assign top_idx = ras_cnt[1:0] - 2'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  state_d = EXEC;
      EXEC:   state_d = UPDATE;
      UPDATE: state_d = run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Branch decisions use the flags of the previous flag-writing instruction.
  always_comb begin
    br_take   = 1'b0;
    br_target = label;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    if (opcode == 3'b011) begin
      case (fcode)
        4'd0: br_take = 1'b1;
        4'd1: br_take = flags_q[2];
        4'd2: br_take = ~flags_q[2];
        4'd3: br_take = flags_q[3];
        4'd4: br_take = ~flags_q[3];
        4'd5: br_take = flags_q[0];
        4'd6: br_take = ~flags_q[0];
        4'd7: br_take = flags_q[1];
        4'd8: br_take = ~flags_q[1];
        4'd9: begin
          br_take = 1'b1;
          push    = 1'b1;
          err_set = (ras_cnt == 3'd4);
        end
        4'd10: begin
          if (ras_cnt != 3'd0) begin
            br_take   = 1'b1;
            pop       = 1'b1;
            br_target = ras[top_idx];
          end else begin
            err_set = 1'b1;
          end
        end
        default: br_take = 1'b0;
      endcase
    end else if (opcode == 3'b100) begin
      br_take = 1'b1;
    end
    next_pc = br_take ? br_target : pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      PC        <= '0;
      next_pc_q <= '0;
      taken     <= 1'b0;
      flags_q   <= '0;
      ras_cnt   <= '0;
      rasErr    <= 1'b0;
      for (int i = 0; i < 4; i++) ras[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) begin
        next_pc_q <= next_pc;
        taken     <= br_take;
        if (flagWe) flags_q <= {carryIn, zIn, overflowIn, signIn};
        if (err_set) rasErr <= 1'b1;
        if (push) begin
          // A full stack drops its oldest entry (slot 0) to make room.
          if (ras_cnt == 3'd4) begin
            ras[0] <= ras[1];
            ras[1] <= ras[2];
            ras[2] <= ras[3];
            ras[3] <= pc_inc;
          end else begin
            ras[ras_cnt[1:0]] <= pc_inc;
            ras_cnt           <= ras_cnt + 3'd1;
          end
        end else if (pop) begin
          ras_cnt <= ras_cnt - 3'd1;
        end
      end
      if (state_q == UPDATE) PC <= next_pc_q;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, conditional branches, call/return
// through the return stack, PC wrap, and asynchronous reset in the middle of EXEC.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [2:0] opcode;
  logic [3:0] fcode;
  logic [9:0] label;
  logic       flagWe, carryIn, zIn, overflowIn, signIn;
  logic [9:0] PC;
  logic       irWrite, exeEn, taken, rasErr;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .fcode(fcode), .label(label),
    .flagWe(flagWe), .carryIn(carryIn), .zIn(zIn), .overflowIn(overflowIn), .signIn(signIn),
    .PC(PC), .irWrite(irWrite), .exeEn(exeEn), .taken(taken), .state(state), .rasErr(rasErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [3:0] fc, input logic [9:0] lbl,
                           input logic fwe, input logic [3:0] fl);
    opcode = op; fcode = fc; label = lbl; flagWe = fwe;
    {carryIn, zIn, overflowIn, signIn} = fl;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (state !== 2'b01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("fetch_timeout", 32'(state), 32'h1);
  endtask

  // Runs one full FETCH/EXEC/UPDATE pass; returns at the negedge after the PC update.
  task automatic do_instr(input logic [2:0] op, input logic [3:0] fc, input logic [9:0] lbl,
                          input logic fwe, input logic [3:0] fl);
    wait_fetch();
    set_instr(op, fc, lbl, fwe, fl);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_pc(input string tag, input logic [9:0] pc_e, input logic tk_e);
    check({tag, "_pc"}, 32'(PC), 32'(pc_e));
    check({tag, "_taken"}, 32'(taken), 32'(tk_e));
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    set_instr(3'b000, 4'd0, 10'd0, 1'b0, 4'b0000);
    #1;
    check("rst_state", 32'(state), 32'h0);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_rasErr", 32'(rasErr), 32'h0);
    check("rst_irWrite", 32'(irWrite), 32'h0);
    repeat (2) @(negedge clk);
    check("idle_hold", 32'(state), 32'h0);
    rst_n = 1'b1;
    run   = 1'b1;
    check("idle_before_edge", 32'(state), 32'h0);

    @(negedge clk);
    check("walk_fetch", 32'(state), 32'h1);
    check("walk_irWrite", 32'(irWrite), 32'h1);
    @(negedge clk);
    check("walk_exec", 32'(state), 32'h2);
    check("walk_exeEn", 32'(exeEn), 32'h1);
    check("walk_exec_irWrite", 32'(irWrite), 32'h0);
    check("walk_exec_pc_held", 32'(PC), 32'h0);
    @(negedge clk);
    check("walk_update", 32'(state), 32'h3);
    @(negedge clk);
    check("walk_refetch", 32'(state), 32'h1);
    expect_pc("seq1", 10'h001, 1'b0);
    do_instr(3'b000, 4'd0, 10'd0, 1'b0, 4'b0000);
    expect_pc("seq2", 10'h002, 1'b0);

    // bz with Z set by an earlier instruction, then with Z cleared
    do_instr(3'b000, 4'd0, 10'd0, 1'b1, 4'b0100);
    expect_pc("setz", 10'h003, 1'b0);
    do_instr(3'b011, 4'd1, 10'h155, 1'b0, 4'b0000);
    expect_pc("bz_taken", 10'h155, 1'b1);
    do_instr(3'b000, 4'd0, 10'd0, 1'b1, 4'b0000);
    expect_pc("clrz", 10'h156, 1'b0);
    do_instr(3'b011, 4'd1, 10'h155, 1'b0, 4'b0000);
    expect_pc("bz_not", 10'h157, 1'b0);
    do_instr(3'b011, 4'd2, 10'h0aa, 1'b0, 4'b0000);
    expect_pc("bnz_taken", 10'h0aa, 1'b1);

    // branch sees the old flags even when it writes new ones in the same EXEC
    do_instr(3'b011, 4'd3, 10'h0f0, 1'b1, 4'b1000);
    expect_pc("bcy_old_flags", 10'h0ab, 1'b0);
    do_instr(3'b011, 4'd3, 10'h0f0, 1'b0, 4'b0000);
    expect_pc("bcy_new_flags", 10'h0f0, 1'b1);
    do_instr(3'b011, 4'd7, 10'h123, 1'b0, 4'b0000);
    expect_pc("bv_not", 10'h0f1, 1'b0);
    do_instr(3'b011, 4'd0, 10'h3c3, 1'b0, 4'b0000);
    expect_pc("b_always", 10'h3c3, 1'b1);

    // call / return
    do_instr(3'b100, 4'd0, 10'h010, 1'b0, 4'b0000);
    expect_pc("jmp", 10'h010, 1'b1);
    do_instr(3'b011, 4'd9, 10'h200, 1'b0, 4'b0000);
    expect_pc("call", 10'h200, 1'b1);
    check("call_cnt", 32'(dut.ras_cnt), 32'h1);
    do_instr(3'b011, 4'd10, 10'h3ff, 1'b0, 4'b0000);
    expect_pc("ret", 10'h011, 1'b1);
    check("ret_cnt", 32'(dut.ras_cnt), 32'h0);
    check("ret_no_err", 32'(rasErr), 32'h0);

    // five nested calls overflow the stack
    do_instr(3'b100, 4'd0, 10'h000, 1'b0, 4'b0000);
    do_instr(3'b011, 4'd9, 10'h100, 1'b0, 4'b0000);
    do_instr(3'b011, 4'd9, 10'h101, 1'b0, 4'b0000);
    do_instr(3'b011, 4'd9, 10'h102, 1'b0, 4'b0000);
    do_instr(3'b011, 4'd9, 10'h103, 1'b0, 4'b0000);
    check("four_calls_no_err", 32'(rasErr), 32'h0);
    check("four_calls_cnt", 32'(dut.ras_cnt), 32'h4);
    do_instr(3'b011, 4'd9, 10'h200, 1'b0, 4'b0000);
    expect_pc("call5", 10'h200, 1'b1);
    check("ovf_err", 32'(rasErr), 32'h1);
    check("ovf_cnt", 32'(dut.ras_cnt), 32'h4);
    do_instr(3'b011, 4'd10, 10'h000, 1'b0, 4'b0000);
    expect_pc("ret1", 10'h104, 1'b1);
    do_instr(3'b011, 4'd10, 10'h000, 1'b0, 4'b0000);
    expect_pc("ret2", 10'h103, 1'b1);
    do_instr(3'b011, 4'd10, 10'h000, 1'b0, 4'b0000);
    expect_pc("ret3", 10'h102, 1'b1);
    do_instr(3'b011, 4'd10, 10'h000, 1'b0, 4'b0000);
    expect_pc("ret4", 10'h101, 1'b1);
    check("ret4_cnt", 32'(dut.ras_cnt), 32'h0);
    do_instr(3'b011, 4'd10, 10'h000, 1'b0, 4'b0000);
    expect_pc("ret5_underflow", 10'h102, 1'b0);
    check("err_sticky", 32'(rasErr), 32'h1);
    check("ret5_cnt", 32'(dut.ras_cnt), 32'h0);

    // PC wrap and reserved fcode
    do_instr(3'b100, 4'd0, 10'h3ff, 1'b0, 4'b0000);
    do_instr(3'b010, 4'd0, 10'h055, 1'b0, 4'b0000);
    expect_pc("wrap", 10'h000, 1'b0);
    do_instr(3'b011, 4'd12, 10'h055, 1'b0, 4'b0000);
    expect_pc("fcode12", 10'h001, 1'b0);

    // asynchronous reset in the middle of a taken call
    do_instr(3'b011, 4'd9, 10'h040, 1'b0, 4'b0000);
    expect_pc("pre_rst_call", 10'h040, 1'b1);
    wait_fetch();
    set_instr(3'b011, 4'd9, 10'h300, 1'b0, 4'b0000);
    @(negedge clk);
    check("mid_exec", 32'(state), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'h0);
    check("arst_pc", 32'(PC), 32'h0);
    check("arst_cnt", 32'(dut.ras_cnt), 32'h0);
    check("arst_taken", 32'(taken), 32'h0);
    check("arst_rasErr", 32'(rasErr), 32'h0);
    check("arst_exeEn", 32'(exeEn), 32'h0);
    repeat (2) @(negedge clk);
    check("arst_hold", 32'(state), 32'h0);
    set_instr(3'b000, 4'd0, 10'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_fetch", 32'(state), 32'h1);
    check("restart_pc", 32'(PC), 32'h0);
    do_instr(3'b000, 4'd0, 10'd0, 1'b0, 4'b0000);
    expect_pc("restart_seq", 10'h001, 1'b0);

    // run dropped: UPDATE returns to IDLE and stays there
    wait_fetch();
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("stop_idle", 32'(state), 32'h0);
    check("stop_pc", 32'(PC), 32'h2);
    repeat (2) @(negedge clk);
    check("stop_hold", 32'(state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
